mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum BUSY cycles to wait for m_ready before aborting a transfer.
REQ-002 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port i_req  input  1  instruction-fetch request; held high until i_ack.
REQ-005 Port i_addr  input  32  fetch address.
REQ-006 Port i_rdata  output  32  fetched word.
REQ-007 Port i_ack  output  1  one-cycle fetch completion pulse.
REQ-008 Port d_req  input  1  data request; held high until d_ack.
REQ-009 Port d_we  input  1  1 = store, 0 = load.
REQ-010 Port d_addr  input  32  data address.
REQ-011 Port d_wdata  input  32  store data.
REQ-012 Port d_rdata  output  32  load data.
REQ-013 Port d_ack  output  1  one-cycle data completion pulse.
REQ-014 Port m_req  output  1  shared memory request.
REQ-015 Port m_we  output  1  shared memory write enable.
REQ-016 Port m_addr  output  32  shared memory address.
REQ-017 Port m_wdata  output  32  shared memory write data.
REQ-018 Port m_rdata  input  32  memory read data, valid when m_ready = 1.
REQ-019 Port m_ready  input  1  memory completion, one cycle.
REQ-020 Port err  output  1  timeout flag, pulses together with the aborted requester's ack.
REQ-021 Port grant  output  2  current owner: 00 none, 01 instr, 10 data.

Function
REQ-022 FSM states: IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D.
REQ-023 IDLE, only i_req high -> BUSY_I. IDLE, only d_req high -> BUSY_D. IDLE, neither high -> stay IDLE.
REQ-024 IDLE, both requests high -> grant the port not granted last (round-robin on register last_grant).
REQ-025 On leaving IDLE, the winner's addr, we and wdata SHALL be latched; m_we = 0 for instruction grants; last_grant updates to the winner.
REQ-026 In BUSY_x: m_req = 1 and m_addr/m_we/m_wdata = latched values, stable for the whole transfer.
REQ-027 In BUSY_x with m_ready = 1: latch m_rdata into x_rdata (loads and fetches only), then -> DONE_x.
REQ-028 In DONE_x: x_ack = 1 for exactly one cycle; m_req = 0; all requests ignored; then -> IDLE.
REQ-029 Latency: req first high in IDLE cycle t -> m_req high in cycle t+1; m_ready in cycle k -> x_ack in cycle k+1.
REQ-030 Minimum spacing: a new grant SHALL NOT start until the cycle after DONE, so back-to-back transfers cost 3 cycles with zero-wait memory.
REQ-031 x_rdata SHALL hold its value until the next successful read completion on that port; stores SHALL leave d_rdata unchanged.
REQ-032 A wait counter SHALL clear on entry to BUSY and increment each BUSY cycle without m_ready.
REQ-033 If the wait counter reaches TIMEOUT without m_ready -> DONE_x, with err = 1 during the ack cycle; x_rdata unchanged; m_req = 0 from the DONE cycle onward.
REQ-034 m_ready while not in BUSY SHALL be ignored.
REQ-035 Deassertion of a granted request mid-transfer SHALL be ignored; the transfer completes and acks.
REQ-036 grant = 01 in BUSY_I/DONE_I, 10 in BUSY_D/DONE_D, 00 in IDLE.

Reset
REQ-037 While reset is high, the block SHALL enter IDLE, with last_grant = instr (so the first tie goes to data), wait counter = 0, and all outputs = 0 (including i_rdata and d_rdata).
REQ-038 Reset during BUSY/DONE SHALL abort the transfer: no ack, no err, m_req = 0 the next cycle.

Verification
REQ-039 Single fetch: i_req = 1, i_addr = 0x100; memory returns 0x00500093 with m_ready 2 cycles after m_req -> m_addr = 0x100, m_we = 0; i_ack one cycle later; i_rdata = 0x00500093.
REQ-040 Tie after reset: i_req and d_req rise together -> data granted first, then instr; a repeated tie -> data, instr order alternates.
REQ-041 Store: d_we = 1, d_addr = 0x2000, d_wdata = 0xDEADBEEF -> m_we = 1 with those values held until m_ready; d_ack pulses; d_rdata unchanged.
REQ-042 Timeout: TIMEOUT = 4, m_ready never asserted -> m_req high 4 cycles, then d_ack = 1 and err = 1 in the same cycle, then IDLE.
REQ-043 Reset mid-transfer: reset in the 2nd BUSY cycle -> next cycle m_req = 0, grant = 00, no ack; a later m_ready is ignored.
REQ-044 Back-to-back with zero-wait memory: d_req held continuously -> d_ack every 3rd cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and data access share one memory
// port, ties alternate round-robin, and a stalled transfer is aborted after TIMEOUT cycles.
module mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ready,
  output logic        err,
  output logic [1:0]  grant
);

  // Wide enough to hold TIMEOUT itself, since the abort fires when the count reaches it.
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    DONE_I,
    DONE_D
  } state_t;

  state_t        state_q, state_d;
  logic          last_data_q, last_data_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          timed_out_q, timed_out_d;
  logic [31:0]   i_rdata_q, i_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;
  logic          pick_data;
  logic          busy;
  logic          done;

  // On a tie the port that did not win last time gets the grant.
  always_comb begin
    pick_data = 1'b0;
    if (i_req && d_req) begin
      pick_data = !last_data_q;
    end else begin
      pick_data = d_req;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_data_d = last_data_q;
    wait_cnt_d  = wait_cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    timed_out_d = timed_out_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          wait_cnt_d  = '0;
          timed_out_d = 1'b0;
          last_data_d = pick_data;
          if (pick_data) begin
            state_d = BUSY_D;
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
          end else begin
            state_d = BUSY_I;
            addr_d  = i_addr;
            we_d    = 1'b0;
            wdata_d = '0;
          end
        end
      end

      BUSY_I, BUSY_D: begin
        if (m_ready) begin
          if (state_q == BUSY_I) begin
            state_d   = DONE_I;
            i_rdata_d = m_rdata;
          end else begin
            state_d = DONE_D;
            if (!we_q) begin
              d_rdata_d = m_rdata;
            end
          end
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
          if (wait_cnt_d == CW'(TIMEOUT)) begin
            timed_out_d = 1'b1;
            if (state_q == BUSY_I) begin
              state_d = DONE_I;
            end else begin
              state_d = DONE_D;
            end
          end
        end
      end

      DONE_I, DONE_D: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_data_q <= 1'b0;
      wait_cnt_q  <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      timed_out_q <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_data_q <= last_data_d;
      wait_cnt_q  <= wait_cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      timed_out_q <= timed_out_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // All outputs decode from registered state, so none depend on this cycle's inputs.
  always_comb begin
    busy = (state_q == BUSY_I) || (state_q == BUSY_D);
    done = (state_q == DONE_I) || (state_q == DONE_D);
  end

  assign m_req   = busy;
  assign m_we    = busy && we_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign i_ack   = (state_q == DONE_I);
  assign d_ack   = (state_q == DONE_D);
  assign err     = done && timed_out_q;
  assign grant   = {(state_q == BUSY_D) || (state_q == DONE_D),
                    (state_q == BUSY_I) || (state_q == DONE_I)};
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed cycle table for the named scenarios, then
// randomized requesters and memory compared against a transaction-level model.
module tb_mem_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ready;
  logic        err;
  logic [1:0]  grant;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .err(err), .grant(grant)
  );

  typedef struct {
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        m_ready;
    logic [31:0] m_rdata;
  } in_t;

  typedef struct {
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [1:0]  grant;
    logic        i_ack;
    logic        d_ack;
    logic        err;
    logic [31:0] i_rdata;
    logic [31:0] d_rdata;
  } out_t;

  typedef struct {
    in_t  in;
    out_t exp;
  } vec_t;

  vec_t vecs[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state: who owns the port, whether the ack cycle is due, and
  // how long the current transfer has waited.
  int          mdl_owner = 0;
  bit          mdl_done = 1'b0;
  bit          mdl_tout = 1'b0;
  bit          mdl_last_data = 1'b0;
  bit          mdl_we = 1'b0;
  int          mdl_waited = 0;
  logic [31:0] mdl_addr = '0;
  logic [31:0] mdl_wdata = '0;
  logic [31:0] mdl_ir = '0;
  logic [31:0] mdl_dr = '0;

  task automatic addVec(
    input logic [31:0] rst, input logic [31:0] ireq, input logic [31:0] iaddr,
    input logic [31:0] dreq, input logic [31:0] dwe, input logic [31:0] daddr,
    input logic [31:0] dwdata, input logic [31:0] mrdy, input logic [31:0] mrdata,
    input logic [31:0] emreq, input logic [31:0] emwe, input logic [31:0] emaddr,
    input logic [31:0] emwdata, input logic [31:0] egrant, input logic [31:0] eiack,
    input logic [31:0] edack, input logic [31:0] eerr, input logic [31:0] eirdata,
    input logic [31:0] edrdata);
    vec_t v;
    v.in.rst       = rst[0];
    v.in.i_req     = ireq[0];
    v.in.i_addr    = iaddr;
    v.in.d_req     = dreq[0];
    v.in.d_we      = dwe[0];
    v.in.d_addr    = daddr;
    v.in.d_wdata   = dwdata;
    v.in.m_ready   = mrdy[0];
    v.in.m_rdata   = mrdata;
    v.exp.m_req    = emreq[0];
    v.exp.m_we     = emwe[0];
    v.exp.m_addr   = emaddr;
    v.exp.m_wdata  = emwdata;
    v.exp.grant    = egrant[1:0];
    v.exp.i_ack    = eiack[0];
    v.exp.d_ack    = edack[0];
    v.exp.err      = eerr[0];
    v.exp.i_rdata  = eirdata;
    v.exp.d_rdata  = edrdata;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input in_t s);
    reset   = s.rst;
    i_req   = s.i_req;
    i_addr  = s.i_addr;
    d_req   = s.d_req;
    d_we    = s.d_we;
    d_addr  = s.d_addr;
    d_wdata = s.d_wdata;
    m_ready = s.m_ready;
    m_rdata = s.m_rdata;
  endtask

  task automatic cmp(input string tag, input int idx, input string field,
                     input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s[%0d] %s: got 0x%08h, expected 0x%08h", tag, idx, field, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input int idx, input out_t e);
    vectors++;
    cmp(tag, idx, "m_req",   {31'b0, m_req},  {31'b0, e.m_req});
    cmp(tag, idx, "m_we",    {31'b0, m_we},   {31'b0, e.m_we});
    cmp(tag, idx, "grant",   {30'b0, grant},  {30'b0, e.grant});
    cmp(tag, idx, "i_ack",   {31'b0, i_ack},  {31'b0, e.i_ack});
    cmp(tag, idx, "d_ack",   {31'b0, d_ack},  {31'b0, e.d_ack});
    cmp(tag, idx, "err",     {31'b0, err},    {31'b0, e.err});
    cmp(tag, idx, "i_rdata", i_rdata, e.i_rdata);
    cmp(tag, idx, "d_rdata", d_rdata, e.d_rdata);
    if (e.m_req) cmp(tag, idx, "m_addr", m_addr, e.m_addr);
    if (e.m_we)  cmp(tag, idx, "m_wdata", m_wdata, e.m_wdata);
  endtask

  task automatic modelStep(input in_t s);
    bit take_d;
    take_d = 1'b0;
    if (s.rst) begin
      mdl_owner = 0; mdl_done = 1'b0; mdl_tout = 1'b0; mdl_last_data = 1'b0;
      mdl_we = 1'b0; mdl_waited = 0; mdl_addr = '0; mdl_wdata = '0;
      mdl_ir = '0; mdl_dr = '0;
    end else if (mdl_owner == 0) begin
      if (s.i_req || s.d_req) begin
        if (s.i_req && s.d_req) take_d = !mdl_last_data;
        else take_d = s.d_req;
        mdl_last_data = take_d;
        mdl_waited = 0;
        mdl_tout = 1'b0;
        if (take_d) begin
          mdl_owner = 2; mdl_addr = s.d_addr; mdl_we = s.d_we; mdl_wdata = s.d_wdata;
        end else begin
          mdl_owner = 1; mdl_addr = s.i_addr; mdl_we = 1'b0; mdl_wdata = '0;
        end
      end
    end else if (!mdl_done) begin
      if (s.m_ready) begin
        if (mdl_owner == 1) mdl_ir = s.m_rdata;
        else if (!mdl_we) mdl_dr = s.m_rdata;
        mdl_done = 1'b1;
      end else begin
        mdl_waited++;
        if (mdl_waited >= TO) begin
          mdl_done = 1'b1;
          mdl_tout = 1'b1;
        end
      end
    end else begin
      mdl_owner = 0;
      mdl_done = 1'b0;
    end
  endtask

  task automatic modelOut(output out_t e);
    e.m_req   = (mdl_owner != 0) && !mdl_done;
    e.m_we    = e.m_req && mdl_we;
    e.m_addr  = mdl_addr;
    e.m_wdata = mdl_wdata;
    e.grant   = (mdl_owner == 1) ? 2'b01 : (mdl_owner == 2) ? 2'b10 : 2'b00;
    e.i_ack   = (mdl_owner == 1) && mdl_done;
    e.d_ack   = (mdl_owner == 2) && mdl_done;
    e.err     = mdl_done && mdl_tout;
    e.i_rdata = mdl_ir;
    e.d_rdata = mdl_dr;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached before the bench finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    in_t  r;
    out_t e;
    bit          i_pend = 1'b0;
    bit          d_pend = 1'b0;
    bit          dw = 1'b0;
    logic [31:0] ia = '0;
    logic [31:0] da = '0;
    logic [31:0] dwd = '0;

    // Columns: rst ireq iaddr dreq dwe daddr dwdata mrdy mrdata | m_req m_we m_addr m_wdata grant iack dack err irdata drdata
    addVec(1,0,0,      0,0,0,0,                 0,0,            0,0,0,0,2'b00,0,0,0,0,0);
    addVec(1,0,0,      0,0,0,0,                 0,0,            0,0,0,0,2'b00,0,0,0,0,0);
    addVec(0,1,'h100,  0,0,0,0,                 0,0,            1,0,'h100,0,2'b01,0,0,0,0,0);
    addVec(0,1,'h100,  0,0,0,0,                 0,0,            1,0,'h100,0,2'b01,0,0,0,0,0);
    addVec(0,1,'h100,  0,0,0,0,                 0,0,            1,0,'h100,0,2'b01,0,0,0,0,0);
    addVec(0,1,'h100,  0,0,0,0,                 1,'h00500093,   0,0,0,0,2'b01,1,0,0,'h00500093,0);
    addVec(0,0,0,      0,0,0,0,                 0,0,            0,0,0,0,2'b00,0,0,0,'h00500093,0);
    addVec(0,0,0,      1,1,'h2000,'hDEADBEEF,   0,0,            1,1,'h2000,'hDEADBEEF,2'b10,0,0,0,'h00500093,0);
    addVec(0,0,0,      1,1,'h2000,'hDEADBEEF,   0,0,            1,1,'h2000,'hDEADBEEF,2'b10,0,0,0,'h00500093,0);
    addVec(0,0,0,      1,1,'h2000,'hDEADBEEF,   1,'h12345678,   0,0,0,0,2'b10,0,1,0,'h00500093,0);
    addVec(0,0,0,      0,0,0,0,                 0,0,            0,0,0,0,2'b00,0,0,0,'h00500093,0);
    addVec(1,0,0,      0,0,0,0,                 0,0,            0,0,0,0,2'b00,0,0,0,0,0);
    addVec(0,1,'h40,   1,0,'h80,0,              0,0,            1,0,'h80,0,2'b10,0,0,0,0,0);
    addVec(0,1,'h40,   1,0,'h80,0,              1,'hAAAA0001,   0,0,0,0,2'b10,0,1,0,0,'hAAAA0001);
    addVec(0,1,'h40,   1,0,'h84,0,              0,0,            0,0,0,0,2'b00,0,0,0,0,'hAAAA0001);
    addVec(0,1,'h40,   1,0,'h84,0,              0,0,            1,0,'h40,0,2'b01,0,0,0,0,'hAAAA0001);
    addVec(0,1,'h40,   1,0,'h84,0,              1,'hBBBB0002,   0,0,0,0,2'b01,1,0,0,'hBBBB0002,'hAAAA0001);
    addVec(0,1,'h44,   1,0,'h84,0,              0,0,            0,0,0,0,2'b00,0,0,0,'hBBBB0002,'hAAAA0001);
    addVec(0,1,'h44,   1,0,'h84,0,              0,0,            1,0,'h84,0,2'b10,0,0,0,'hBBBB0002,'hAAAA0001);
    addVec(0,1,'h44,   1,0,'h84,0,              1,'hCCCC0003,   0,0,0,0,2'b10,0,1,0,'hBBBB0002,'hCCCC0003);
    addVec(0,0,0,      0,0,0,0,                 0,0,            0,0,0,0,2'b00,0,0,0,'hBBBB0002,'hCCCC0003);
    addVec(0,0,0,      1,0,'h300,0,             0,0,            1,0,'h300,0,2'b10,0,0,0,'hBBBB0002,'hCCCC0003);
    addVec(0,0,0,      1,0,'h300,0,             0,0,            1,0,'h300,0,2'b10,0,0,0,'hBBBB0002,'hCCCC0003);
    addVec(0,0,0,      1,0,'h300,0,             0,0,            1,0,'h300,0,2'b10,0,0,0,'hBBBB0002,'hCCCC0003);
    addVec(0,0,0,      1,0,'h300,0,             0,0,            1,0,'h300,0,2'b10,0,0,0,'hBBBB0002,'hCCCC0003);
    addVec(0,0,0,      1,0,'h300,0,             0,0,            0,0,0,0,2'b10,0,1,1,'hBBBB0002,'hCCCC0003);
    addVec(0,0,0,      0,0,0,0,                 1,'hDEAD0000,   0,0,0,0,2'b00,0,0,0,'hBBBB0002,'hCCCC0003);
    addVec(0,1,'h500,  0,0,0,0,                 0,0,            1,0,'h500,0,2'b01,0,0,0,'hBBBB0002,'hCCCC0003);
    addVec(0,1,'h500,  0,0,0,0,                 0,0,            1,0,'h500,0,2'b01,0,0,0,'hBBBB0002,'hCCCC0003);
    addVec(1,1,'h500,  0,0,0,0,                 0,0,            0,0,0,0,2'b00,0,0,0,0,0);
    addVec(0,0,0,      0,0,0,0,                 1,'h1111,       0,0,0,0,2'b00,0,0,0,0,0);
    addVec(0,0,0,      1,0,'h600,0,             1,'h600,        1,0,'h600,0,2'b10,0,0,0,0,0);
    addVec(0,0,0,      1,0,'h600,0,             1,'h600,        0,0,0,0,2'b10,0,1,0,0,'h600);
    addVec(0,0,0,      1,0,'h600,0,             1,'h600,        0,0,0,0,2'b00,0,0,0,0,'h600);
    addVec(0,0,0,      1,0,'h600,0,             1,'h600,        1,0,'h600,0,2'b10,0,0,0,0,'h600);
    addVec(0,0,0,      1,0,'h600,0,             1,'h600,        0,0,0,0,2'b10,0,1,0,0,'h600);
    addVec(0,0,0,      1,0,'h600,0,             1,'h600,        0,0,0,0,2'b00,0,0,0,0,'h600);
    addVec(0,0,0,      1,0,'h600,0,             1,'h600,        1,0,'h600,0,2'b10,0,0,0,0,'h600);
    addVec(0,0,0,      1,0,'h600,0,             1,'h600,        0,0,0,0,2'b10,0,1,0,0,'h600);
    addVec(0,0,0,      0,0,0,0,                 0,0,            0,0,0,0,2'b00,0,0,0,0,'h600);

    $display("[TB] directed table: %0d cycles", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].in);
      @(posedge clk);
      #1;
      checkOutput("dir", i, vecs[i].exp);
    end

    $display("[TB] randomized traffic against reference model");
    for (int c = 0; c < 3000; c++) begin
      r.rst = (c < 2) || ($urandom_range(0, 199) == 0);
      if (!i_pend) begin
        if ($urandom_range(0, 2) == 0) begin
          i_pend = 1'b1;
          ia = $urandom;
        end
      end else if ($urandom_range(0, 39) == 0) begin
        i_pend = 1'b0;
      end
      if (!d_pend) begin
        if ($urandom_range(0, 2) == 0) begin
          d_pend = 1'b1;
          da = $urandom;
          dwd = $urandom;
          dw = ($urandom_range(0, 1) == 1);
        end
      end else if ($urandom_range(0, 39) == 0) begin
        d_pend = 1'b0;
      end
      r.i_req   = i_pend;
      r.i_addr  = ia;
      r.d_req   = d_pend;
      r.d_we    = dw;
      r.d_addr  = da;
      r.d_wdata = dwd;
      r.m_ready = ($urandom_range(0, 2) == 0);
      r.m_rdata = $urandom;
      applyStimulus(r);
      @(posedge clk);
      modelStep(r);
      #1;
      modelOut(e);
      checkOutput("rand", c, e);
      if (e.i_ack) i_pend = 1'b0;
      if (e.d_ack) d_pend = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
